// File: rtl/fetch_unit.sv
// fetch_unit: in-order PC fetch with one outstanding imem read, feeding {pc, inst} entries to the instruction queue
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int IQ_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  output logic [31:0]         imem_addr,
  output logic [3:0]          imem_rmask,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_resp,
  output logic [IQ_WIDTH-1:0] iq_wdata,
  output logic                iq_enqueue,
  input  logic                iq_full,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc
);
  localparam logic [1:0] REQ = 2'd0, WAIT = 2'd1, STALL = 2'd2, DISCARD = 2'd3;
  logic [1:0] state_q, state_d;
  logic [31:0] pc_q, pc_d, hold_q, hold_d, pc_inc;
  logic go, accept, rel, fire, req;
  always_comb begin
    pc_inc = pc_q + 32'd4;
    go = !rst && !redirect;
    accept = state_q == WAIT && imem_resp && !iq_full;
    rel = state_q == STALL && !iq_full;
    fire = go && (accept || rel);
    req = go && (fire || state_q == REQ || (state_q == DISCARD && imem_resp));
    iq_enqueue = fire;
    iq_wdata = fire ? IQ_WIDTH'({pc_q, state_q == STALL ? hold_q : imem_rdata}) : '0;
    imem_rmask = req ? 4'hf : 4'h0;
    imem_addr = rst ? RESET_PC : fire ? pc_inc : pc_q;
    pc_d = redirect ? {redirect_pc[31:2], 2'b00} : fire ? pc_inc : pc_q;
    hold_d = state_q == WAIT && imem_resp && iq_full ? imem_rdata : hold_q;
    // a redirect with a read still in flight must swallow that stale response
    state_d = redirect ? (((state_q == WAIT || state_q == DISCARD) && !imem_resp) ? DISCARD : REQ)
            : state_q == REQ   ? WAIT
            : state_q == WAIT  ? ((imem_resp && iq_full) ? STALL : WAIT)
            : state_q == STALL ? (iq_full ? STALL : WAIT)
            : (imem_resp ? WAIT : DISCARD);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      pc_q <= RESET_PC;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      hold_q <= hold_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios against a latency-programmable memory and a transaction-level fetch-stream model
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h1eceb000;
  localparam logic [31:0] D = 32'hdeadbeef;
  logic clk = 0, rst, imem_resp, iq_enqueue, iq_full, redirect;
  logic [31:0] imem_addr, imem_rdata, redirect_pc;
  logic [3:0] imem_rmask;
  logic [63:0] iq_wdata;
  int total = 0, bad = 0, mem_lat;
  logic mpend;
  logic [31:0] maddr;
  int mcnt;
  logic outst, stale, held, enq_exp, req_exp;
  logic [31:0] exp_pc;

  fetch_unit #(.RESET_PC(RESET_PC), .IQ_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp), .iq_wdata(iq_wdata),
    .iq_enqueue(iq_enqueue), .iq_full(iq_full), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #10 clk = ~clk;

  assign imem_resp = mpend && mcnt == 0;
  assign imem_rdata = imem_resp ? maddr ^ D : 32'h0;
  always @(posedge clk) begin
    if (rst) mpend <= 1'b0;
    else begin
      if (imem_resp) mpend <= 1'b0;
      else if (mpend) mcnt <= mcnt - 1;
      if (imem_rmask == 4'hf) begin
        mpend <= 1'b1;
        maddr <= imem_addr;
        mcnt <= mem_lat;
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic look(input string n, input logic en, input logic [63:0] wd, input logic [3:0] rm, input logic [31:0] ad);
    chk({n, "_enq"}, 64'(iq_enqueue), 64'(en));
    chk({n, "_wdata"}, iq_wdata, en ? wd : 64'h0);
    chk({n, "_rmask"}, 64'(imem_rmask), 64'(rm));
    if (rm != 4'h0) chk({n, "_addr"}, 64'(imem_addr), 64'(ad));
  endtask

  // Fetch-stream model: every request and every enqueue names the next pc the program order needs.
  always begin
    @(negedge clk);
    #6;
    if (rst) begin
      chk("m_rst_quiet", {59'h0, iq_enqueue, imem_rmask}, 64'h0);
      outst = 0; stale = 0; held = 0; exp_pc = RESET_PC;
    end else begin
      enq_exp = !redirect && !iq_full && (held || (imem_resp && !stale));
      req_exp = !redirect && (enq_exp || (imem_resp && stale) || (!outst && !held));
      chk("m_enq", 64'(iq_enqueue), 64'(enq_exp));
      chk("m_rmask", 64'(imem_rmask), req_exp ? 64'hf : 64'h0);
      if (enq_exp) begin
        chk("m_wdata", iq_wdata, {exp_pc, exp_pc ^ D});
        exp_pc = exp_pc + 32'd4;
      end
      if (req_exp) chk("m_addr", 64'(imem_addr), 64'(exp_pc));
      if (redirect) begin
        stale = outst && !imem_resp;
        outst = stale;
        held = 0;
        exp_pc = redirect_pc & ~32'h3;
      end else begin
        if (imem_resp && !stale && iq_full && !held) held = 1;
        else if (enq_exp) held = 0;
        if (imem_resp) stale = 0;
        outst = (outst && !imem_resp) || req_exp;
      end
    end
  end

  task automatic idle(input string n);
    look(n, 1'b0, 64'h0, 4'h0, 32'h0);
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  initial begin
    rst = 1; iq_full = 0; redirect = 0; redirect_pc = 0; mem_lat = 1;
    cyc; #5;
    idle("rst");
    chk("rst_addr", 64'(imem_addr), 64'(RESET_PC));
    cyc; rst = 0; #5; look("first_req", 0, 0, 4'hf, 32'h1eceb000);
    cyc; #5; idle("b");
    cyc; #5; look("enq0", 1, 64'h1eceb000_c0630eef, 4'hf, 32'h1eceb004);
    cyc; #5; idle("d");
    cyc; iq_full = 1; #5; idle("full_resp");
    repeat (4) begin cyc; #5; idle("full_hold"); end
    cyc; iq_full = 0; #5; look("stall_rel", 1, {32'h1eceb004, 32'h1eceb004 ^ D}, 4'hf, 32'h1eceb008);
    cyc; #5; idle("k");
    cyc; mem_lat = 3; #5; look("enq8", 1, {32'h1eceb008, 32'h1eceb008 ^ D}, 4'hf, 32'h1eceb00c);
    cyc; mem_lat = 1; redirect = 1; redirect_pc = 32'h1ecec103; #5; idle("redir_wait");
    cyc; redirect = 0; #5; idle("disc1");
    cyc; #5; idle("disc2");
    cyc; #5; look("stale_resp", 0, 0, 4'hf, 32'h1ecec100);
    cyc; #5; idle("q");
    cyc; #5; look("redir_enq", 1, {32'h1ecec100, 32'h1ecec100 ^ D}, 4'hf, 32'h1ecec104);
    cyc; #5; idle("s");
    cyc; redirect = 1; redirect_pc = 32'hfffffffc; #5; idle("redir_resp");
    cyc; redirect = 0; #5; look("redir_req", 0, 0, 4'hf, 32'hfffffffc);
    cyc; #5; idle("v");
    cyc; #5; look("wrap", 1, 64'hfffffffc_21524113, 4'hf, 32'h0);
    cyc; #5; idle("x");
    cyc; iq_full = 1; #5; idle("hold0");
    cyc; rst = 1; #5; idle("rst_stall");
    cyc; rst = 0; iq_full = 0; #5; look("post_rst", 0, 0, 4'hf, RESET_PC);
    cyc; #5; idle("ab");
    cyc; #5; look("post_rst_enq", 1, 64'h1eceb000_c0630eef, 4'hf, 32'h1eceb004);
    repeat (60) begin
      cyc;
      iq_full = $urandom_range(0, 3) == 0;
      redirect = $urandom_range(0, 11) == 0;
      redirect_pc = $urandom;
      mem_lat = $urandom_range(1, 3);
    end
    cyc; iq_full = 0; redirect = 0; mem_lat = 1;
    repeat (8) cyc;
    #8;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

In-order instruction fetch stage of the out-of-order core. Holds the PC and issues word reads to the instruction memory port with one request outstanding. Pushes {pc, instruction} entries into the instruction queue, the FIFO between fetch and decode. Redirects to a new PC on a branch/jump redirect from the back end, discarding any stale in-flight response.

## Interface
Parameters:
- RESET_PC, 32'h1eceb000, PC fetched first after reset
- IQ_WIDTH, 64, instruction-queue entry width; entry = {pc[31:0], inst[31:0]}

Ports:
- clk  in  1  clock; the only clock
- rst  in  1  reset; synchronous, active-high
- imem_addr  out  32  fetch address; word aligned
- imem_rmask  out  4  4'b1111 for exactly the request cycle, else 4'b0000
- imem_rdata  in  32  instruction word; valid when imem_resp=1
- imem_resp  in  1  single-cycle response strobe for the outstanding request
- iq_wdata  out  IQ_WIDTH  entry to instruction queue, {pc, inst}
- iq_enqueue  out  1  push strobe; never asserted while iq_full=1
- iq_full  in  1  instruction queue full
- redirect  in  1  single-cycle redirect request from branch resolution
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and forced to 0

## Operation
- Registers: pc (32 bits), hold_inst (32 bits), state in {REQ, WAIT, STALL, DISCARD}.
- REQ: drive imem_addr=pc, imem_rmask=4'b1111, then go to WAIT.
- WAIT, imem_resp=1, iq_full=0:
  - iq_enqueue=1, iq_wdata={pc, imem_rdata}.
  - In the same cycle, issue a request for pc+4 (imem_addr=pc+4, rmask=1111).
  - pc<=pc+4; stay in WAIT.
- WAIT, imem_resp=1, iq_full=1: hold_inst<=imem_rdata; go to STALL; no request.
- WAIT, imem_resp=0: hold all outputs idle.
- STALL, iq_full=0: iq_enqueue=1 with {pc, hold_inst}; issue a request for pc+4; pc<=pc+4; go to WAIT.
- STALL, iq_full=1: remain in STALL.
- DISCARD: a stale request is outstanding.
  - On imem_resp, drop the data (no enqueue), issue a request for pc in the same cycle, and go to WAIT.
- Redirect has the highest priority, in every state.
  - pc<=redirect_pc&~3.
  - iq_enqueue=0 and imem_rmask=0 in the redirect cycle.
  - A hold_inst entry, or any imem_resp arriving in that cycle, is discarded.
  - Next state:
    - DISCARD if a request is outstanding and no response arrived this cycle (WAIT with imem_resp=0, or DISCARD with imem_resp=0).
    - Otherwise REQ.
- At most one request is outstanding at any time. Requests are never issued while in WAIT or DISCARD except in the response cycle.
- Arithmetic: the PC increment is a 32-bit add that wraps modulo 2^32 (32'hfffffffc+4 = 0).

## Timing
- Reset values: pc=RESET_PC, state=REQ, imem_rmask=0, iq_enqueue=0, iq_wdata=0, imem_addr=RESET_PC.
- The first request goes out in the first cycle after rst deasserts.
- Response-to-enqueue latency is 0 cycles, combinational from imem_resp. The follow-on request goes out in the same cycle.
- With a 1-cycle memory and the queue never full, throughput is one instruction every 2 cycles.
- Redirect-to-request latency:
  - 1 cycle if no request is outstanding.
  - If a request is outstanding, the request goes out in the cycle of the stale response.
- Stall release: enqueue happens in the first cycle iq_full=0 is sampled.
- Asserting rst mid-operation aborts everything: the next cycle is in REQ at RESET_PC. A pending memory response arriving after reset is treated as the response to the new request. The memory model must also be reset.
- iq_enqueue and imem_rmask are purely functions of the current state and inputs. No output is asserted in the cycle rst=1.

## Test plan
- Reset, then a 1-cycle memory returning inst=addr^32'hdeadbeef, with the queue never full: enqueues at PCs 1eceb000, 1eceb004, 1eceb008… on every other cycle, and data matches.
- iq_full held high for 5 cycles when the second response arrives: no enqueue while full. Entry {1eceb004, inst} is enqueued on the first cycle not full. Then a request for 1eceb008.
- redirect to 32'h1ecec103 while in WAIT, with the response arriving 3 cycles later: the stale response is not enqueued, and the next request and enqueue use pc 1ecec100.
- redirect in the same cycle as imem_resp: no enqueue that cycle, and a request to redirect_pc on the next cycle.
- pc=32'hfffffffc, response accepted: the entry pc is fffffffc and the next request address is 00000000.
- rst asserted during STALL: the next cycle has imem_rmask=1111 and addr=RESET_PC, and the held instruction is never enqueued.
